// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, least significant digit first.
// Subtraction adds the nines' complement of b with a forced carry-in, giving tens' complement plus borrow.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start,
  input  logic                  op,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry_out,
  output logic                  busy,
  output logic                  done,
  output logic                  invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             c_q, c_d;
  logic             op_q, op_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic             invalid_q, invalid_d;

  logic [3:0]       bd;
  logic [4:0]       sum;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Returns {carry, digit}; inputs are valid BCD digits so t never exceeds 19.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] ad, input logic [3:0] bdig,
                                               input logic c);
    logic [4:0] t;
    logic [4:0] t_adj;
    t     = {1'b0, ad} + {1'b0, bdig} + {4'b0000, c};
    t_adj = t - 5'd10;
    if (t > 5'd9) return {1'b1, t_adj[3:0]};
    return {1'b0, t[3:0]};
  endfunction

  assign bd  = op_q ? (4'd9 - b_sh_q[3:0]) : b_sh_q[3:0];
  assign sum = bcd_digit_add(a_sh_q[3:0], bd, c_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    c_d       = c_q;
    op_d      = op_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    result_d  = result_q;
    carry_d   = carry_q;
    done_d    = 1'b0;
    invalid_d = invalid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d = a;
          b_sh_d = b;
          op_d   = op;
          if (has_bad_digit(a) || has_bad_digit(b)) begin
            done_d    = 1'b1;
            invalid_d = 1'b1;
            result_d  = '0;
            carry_d   = 1'b0;
          end else begin
            state_d   = S_RUN;
            invalid_d = 1'b0;
            idx_d     = '0;
            c_d       = op | cin;
          end
        end
      end
      S_RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = sum[3:0];
        c_d    = sum[4];
        a_sh_d = a_sh_q >> 4;
        b_sh_d = b_sh_q >> 4;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          carry_d = op_q ? ~sum[4] : sum[4];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      c_q       <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      c_q       <= c_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
    end
  end

  // Operand shift registers carry only data and need no reset.
  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
    op_q   <= op_d;
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (DIGITS=4) with hand-computed BCD results.
module tb_bcd_serial_addsub;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic        op;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        carry_out;
  logic        busy;
  logic        done;
  logic        invalid;

  int checks;
  int failures;

  bcd_serial_addsub #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .op        (op),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .result    (result),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request; returns busy/done seen right after the sampling edge and the
  // number of further edges until done (capped at 20).
  task automatic do_req(input logic o, input logic ci, input logic [15:0] av,
                        input logic [15:0] bv, output logic busy0, output logic done0,
                        output int cyc);
    op = o; cin = ci; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; op = ~o; cin = ~ci;
    busy0 = busy; done0 = done;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  logic bz, dn;
  int   cyc, ndone;
  logic [15:0] res_seen;

  initial begin
    checks = 0; failures = 0;
    rst_b = 1'b0; start = 1'b0; op = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_invalid", invalid, 0);
    chk("rst_carry", carry_out, 0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // 1: full carry chain out of the top digit
    do_req(1'b0, 1'b0, 16'h1234, 16'h8766, bz, dn, cyc);
    chk("t1_busy0", bz, 1);
    chk("t1_done0", dn, 0);
    chk("t1_lat", cyc, 4);
    chk("t1_res", result, 16'h0000);
    chk("t1_cout", carry_out, 1);
    chk("t1_busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("t1_done_pulse", done, 0);

    // 2: carry-in ripples through three digits
    do_req(1'b0, 1'b1, 16'h0999, 16'h0001, bz, dn, cyc);
    chk("t2_lat", cyc, 4);
    chk("t2_res", result, 16'h1001);
    chk("t2_cout", carry_out, 0);

    // 3: subtraction without and with borrow; cin ignored in subtract
    do_req(1'b1, 1'b0, 16'h0500, 16'h0123, bz, dn, cyc);
    chk("t3a_res", result, 16'h0377);
    chk("t3a_borrow", carry_out, 0);
    do_req(1'b1, 1'b1, 16'h0123, 16'h0500, bz, dn, cyc);
    chk("t3b_res", result, 16'h9623);
    chk("t3b_borrow", carry_out, 1);
    do_req(1'b1, 1'b1, 16'h0005, 16'h0005, bz, dn, cyc);
    chk("t3c_res", result, 16'h0000);
    chk("t3c_borrow", carry_out, 0);
    do_req(1'b0, 1'b1, 16'h9999, 16'h9999, bz, dn, cyc);
    chk("t3d_res", result, 16'h9999);
    chk("t3d_cout", carry_out, 1);

    // 4: invalid digit in a; result previously nonzero
    do_req(1'b0, 1'b0, 16'h12A4, 16'h0000, bz, dn, cyc);
    chk("t4_busy0", bz, 0);
    chk("t4_done0", dn, 1);
    chk("t4_lat", cyc, 0);
    chk("t4_invalid", invalid, 1);
    chk("t4_res", result, 16'h0000);
    chk("t4_cout", carry_out, 0);
    @(posedge clk); #1;
    chk("t4_done_pulse", done, 0);
    chk("t4_invalid_held", invalid, 1);
    do_req(1'b0, 1'b0, 16'h0011, 16'h0022, bz, dn, cyc);
    chk("t4_valid_invalid", invalid, 0);
    chk("t4_valid_res", result, 16'h0033);

    // 5a: start pulsed during RUN is ignored
    op = 1'b0; cin = 1'b0; a = 16'h0101; b = 16'h0202; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h4444; b = 16'h4444;
    ndone = 0; res_seen = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy && done) chk("t5_busy_and_done", 1, 0);
      if (done) begin
        ndone++;
        res_seen = result;
      end
    end
    chk("t5_ndone", ndone, 1);
    chk("t5_res", res_seen, 16'h0303);

    // 5b: back-to-back request accepted in the done cycle
    do_req(1'b0, 1'b0, 16'h2000, 16'h3000, bz, dn, cyc);
    chk("t5b_res1", result, 16'h5000);
    do_req(1'b0, 1'b0, 16'h5000, 16'h6000, bz, dn, cyc);
    chk("t5b_busy0", bz, 1);
    chk("t5b_done0", dn, 0);
    chk("t5b_lat", cyc, 4);
    chk("t5b_res2", result, 16'h1000);
    chk("t5b_cout2", carry_out, 1);

    // 6: reset during RUN aborts without a done pulse
    op = 1'b0; cin = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk("t6_res", result, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_carry", carry_out, 0);
    chk("t6_invalid", invalid, 0);
    rst_b = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("t6_no_done", ndone, 0);
    do_req(1'b0, 1'b0, 16'h0042, 16'h0058, bz, dn, cyc);
    chk("t6_after_lat", cyc, 4);
    chk("t6_after_res", result, 16'h0100);
    chk("t6_after_cout", carry_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
